// File: rtl/line_window_buffer_if.sv
// Pixel-stream bus between a CCD front end and the line window buffer.
// The source drives the frame/line strobes and pixel data; the buffer
// returns the vertical window column plus status.
interface line_window_buffer_if #(
    parameter int DATA_W    = 10,
    parameter int MAX_PIX   = 1280,
    parameter int NUM_LINES = 3
);
    localparam int ADDR_W = $clog2(MAX_PIX + 1);
    localparam int WR_W   = $clog2(NUM_LINES);

    logic                        mCCD_FVAL;
    logic                        mCCD_LVAL;
    logic [DATA_W-1:0]           mCCD_DATA;
    logic [DATA_W*NUM_LINES-1:0] oDATA;
    logic                        oVALID;
    logic [ADDR_W-1:0]           oX;
    logic                        oWIN_READY;
    logic                        oOVF;
    logic [WR_W-1:0]             WR;

    modport master (
        output mCCD_FVAL, mCCD_LVAL, mCCD_DATA,
        input  oDATA, oVALID, oX, oWIN_READY, oOVF, WR
    );

    modport slave (
        input  mCCD_FVAL, mCCD_LVAL, mCCD_DATA,
        output oDATA, oVALID, oX, oWIN_READY, oOVF, WR
    );
endinterface

// File: rtl/line_window_buffer.sv
// Line window buffer: stores the previous NUM_LINES-1 lines of a frame in
// rotating line RAMs and presents, one cycle after each accepted pixel, the
// vertical column {older lines..., current pixel} at the same X position.
module line_window_buffer #(
    parameter int DATA_W    = 10,
    parameter int MAX_PIX   = 1280,
    parameter int NUM_LINES = 3
) (
    input  logic               CCD_PIXCLK,
    input  logic               RESET_N,
    line_window_buffer_if.slave bus
);
    localparam int ADDR_W = $clog2(MAX_PIX + 1);
    localparam int WR_W   = $clog2(NUM_LINES);
    localparam int RAM_AW = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
    localparam logic [ADDR_W-1:0] X_MAX     = ADDR_W'(MAX_PIX);
    localparam logic [WR_W-1:0]   LAST_BANK = WR_W'(NUM_LINES - 1);

    // Bank index arithmetic is always modulo NUM_LINES; operands stay below
    // NUM_LINES so a single conditional subtract folds the sum back.
    function automatic logic [WR_W-1:0] mod_add(input logic [WR_W-1:0] a,
                                                input logic [WR_W-1:0] b);
        logic [WR_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (WR_W+1)'(NUM_LINES))
            s = s - (WR_W+1)'(NUM_LINES);
        return s[WR_W-1:0];
    endfunction

    logic              fval_q, lval_q;
    logic [ADDR_W-1:0] x;
    logic [WR_W-1:0]   wr, lines_stored;
    logic              accept, in_range, line_end, fval_rise;
    logic [RAM_AW-1:0] addr;

    assign accept    = bus.mCCD_FVAL & bus.mCCD_LVAL;
    assign in_range  = (x < X_MAX);
    assign line_end  = lval_q & ~bus.mCCD_LVAL & bus.mCCD_FVAL;
    assign fval_rise = bus.mCCD_FVAL & ~fval_q;
    assign addr      = x[RAM_AW-1:0];

    // Column counter, write bank and history depth; FVAL low wins over a line end.
    always_ff @(posedge CCD_PIXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fval_q       <= 1'b0;
            lval_q       <= 1'b0;
            x            <= '0;
            wr           <= '0;
            lines_stored <= '0;
        end else begin
            fval_q <= bus.mCCD_FVAL;
            lval_q <= bus.mCCD_LVAL;
            if (!bus.mCCD_FVAL) begin
                x            <= '0;
                wr           <= '0;
                lines_stored <= '0;
            end else if (line_end) begin
                x  <= '0;
                wr <= mod_add(wr, WR_W'(1));
                if (lines_stored != LAST_BANK)
                    lines_stored <= lines_stored + WR_W'(1);
            end else if (accept && in_range) begin
                x <= x + ADDR_W'(1);
            end
        end
    end

    // One RAM per line slot; all banks are read at the current column while
    // the active bank is written, so the window column appears next cycle.
    logic [DATA_W-1:0] bank_rd [NUM_LINES];

    for (genvar b = 0; b < NUM_LINES; b++) begin : g_bank
        logic [DATA_W-1:0] mem [MAX_PIX];
        logic [DATA_W-1:0] rd_q;

        // Synchronous read-before-write line RAM, contents survive reset.
        always_ff @(posedge CCD_PIXCLK) begin
            if (accept && in_range) begin
                if (wr == WR_W'(b))
                    mem[addr] <= bus.mCCD_DATA;
                rd_q <= mem[addr];
            end
        end

        assign bank_rd[b] = rd_q;
    end

    logic              vld_q, beyond_q, win_q, ovf_q;
    logic [DATA_W-1:0] pix_q;
    logic [ADDR_W-1:0] x_q;
    logic [WR_W-1:0]   wr_q, ls_q;

    // Output-stage context captured alongside the RAM read; overflow is sticky per frame.
    always_ff @(posedge CCD_PIXCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vld_q    <= 1'b0;
            beyond_q <= 1'b0;
            win_q    <= 1'b0;
            ovf_q    <= 1'b0;
            pix_q    <= '0;
            x_q      <= '0;
            wr_q     <= '0;
            ls_q     <= '0;
        end else begin
            vld_q <= accept;
            win_q <= (lines_stored == LAST_BANK);
            if (accept) begin
                pix_q    <= bus.mCCD_DATA;
                x_q      <= x;
                wr_q     <= wr;
                ls_q     <= lines_stored;
                beyond_q <= ~in_range;
            end
            if (accept && !in_range)
                ovf_q <= 1'b1;
            else if (fval_rise)
                ovf_q <= 1'b0;
        end
    end

    logic [NUM_LINES-1:0][DATA_W-1:0] window;

    // Assemble the column: lane k is the line k rows up, blanked when that
    // line is not yet stored this frame or the pixel lies past the RAM end.
    always_comb begin
        window = '0;
        if (vld_q) begin
            window[0] = pix_q;
            for (int k = 1; k < NUM_LINES; k++) begin
                if (!beyond_q && (WR_W'(k) <= ls_q))
                    window[k] = bank_rd[mod_add(wr_q, WR_W'(NUM_LINES - k))];
            end
        end
    end

    assign bus.oDATA      = window;
    assign bus.oVALID     = vld_q;
    assign bus.oX         = x_q;
    assign bus.oWIN_READY = win_q;
    assign bus.oOVF       = ovf_q;
    assign bus.WR         = wr;
endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: random and patterned lines are checked
// against a line-history model (line number mod NUM_LINES picks the slot).
module tb_line_window_buffer;
    localparam int DW = 10;
    localparam int MP = 8;
    localparam int NL = 3;
    localparam int AW = $clog2(MP + 1);
    localparam int WW = $clog2(NL);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    line_window_buffer_if #(.DATA_W(DW), .MAX_PIX(MP), .NUM_LINES(NL)) bus ();

    line_window_buffer #(.DATA_W(DW), .MAX_PIX(MP), .NUM_LINES(NL)) dut (
        .CCD_PIXCLK (clk),
        .RESET_N    (rst_n),
        .bus        (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model state: line number within frame, sticky overflow, slot contents
    int            m_line = 0;
    bit            m_ovf  = 1'b0;
    logic [DW-1:0] m_mem [NL][MP];

    logic [DW-1:0]    pix_in   [16];
    logic [DW*NL-1:0] cap_data [16];
    logic [DW*NL-1:0] exp_data [16];
    logic             cap_vld  [16];
    logic [AW-1:0]    cap_x    [16];
    logic [AW-1:0]    exp_x    [16];
    logic             cap_win  [16];
    logic             exp_win  [16];
    logic             cap_ovf  [16];
    logic             exp_ovf  [16];
    logic [WW-1:0]    line_wr;
    logic             gap_vld;
    logic [DW*NL-1:0] gap_data;

    function automatic logic [DW*NL-1:0] model_window(input int col, input logic [DW-1:0] pix);
        logic [DW*NL-1:0] w;
        int hist;
        w    = '0;
        hist = (m_line < NL - 1) ? m_line : NL - 1;
        w[DW-1:0] = pix;
        if (col < MP)
            for (int k = 1; k <= hist; k++)
                w[k*DW +: DW] = m_mem[(m_line - k) % NL][col];
        return w;
    endfunction

    task automatic grab(input int j);
        cap_vld[j]  = bus.oVALID;
        cap_data[j] = bus.oDATA;
        cap_x[j]    = bus.oX;
        cap_win[j]  = bus.oWIN_READY;
        cap_ovf[j]  = bus.oOVF;
    endtask

    // Drive one line of pix_in[0..n-1], record outputs and model expectations.
    task automatic send_line(input int n, input bit drop_fval);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) grab(i - 1);
            else       line_wr = bus.WR;
            if (!bus.mCCD_FVAL) m_ovf = 1'b0;
            exp_x[i]    = AW'((i < MP) ? i : MP);
            exp_data[i] = model_window(i, pix_in[i]);
            exp_win[i]  = (m_line >= NL - 1);
            if (i >= MP) m_ovf = 1'b1;
            exp_ovf[i]  = m_ovf;
            if (i < MP) m_mem[m_line % NL][i] = pix_in[i];
            bus.mCCD_FVAL = 1'b1;
            bus.mCCD_LVAL = 1'b1;
            bus.mCCD_DATA = pix_in[i];
        end
        @(negedge clk);
        grab(n - 1);
        bus.mCCD_LVAL = 1'b0;
        if (drop_fval) begin
            bus.mCCD_FVAL = 1'b0;
            m_line = 0;
        end else begin
            m_line++;
        end
        @(negedge clk);
        gap_vld  = bus.oVALID;
        gap_data = bus.oDATA;
    endtask

    task automatic end_frame();
        @(negedge clk);
        bus.mCCD_FVAL = 1'b0;
        bus.mCCD_LVAL = 1'b0;
        m_line = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mCCD_FVAL = 1'b0;
        bus.mCCD_LVAL = 1'b0;
        bus.mCCD_DATA = '0;
        repeat (3) @(negedge clk);
        n_chk++; if (bus.oVALID !== 1'b0)     begin n_fail++; $display("FAIL reset_oVALID got=%b want=0", bus.oVALID); end
        n_chk++; if (bus.oDATA !== '0)        begin n_fail++; $display("FAIL reset_oDATA got=%h want=0", bus.oDATA); end
        n_chk++; if (bus.oX !== '0)           begin n_fail++; $display("FAIL reset_oX got=%0d want=0", bus.oX); end
        n_chk++; if (bus.oWIN_READY !== 1'b0) begin n_fail++; $display("FAIL reset_oWIN_READY got=%b want=0", bus.oWIN_READY); end
        n_chk++; if (bus.oOVF !== 1'b0)       begin n_fail++; $display("FAIL reset_oOVF got=%b want=0", bus.oOVF); end
        n_chk++; if (bus.WR !== '0)           begin n_fail++; $display("FAIL reset_WR got=%0d want=0", bus.WR); end
        rst_n = 1'b1;
        m_line = 0;
        m_ovf  = 1'b0;
        @(negedge clk);
    endtask

    // Fill every slot at every column so later stale reads are well defined.
    task automatic test_prime();
        for (int ln = 0; ln < NL; ln++) begin
            for (int i = 0; i < MP; i++) pix_in[i] = DW'($urandom);
            send_line(MP, 1'b0);
            for (int i = 0; i < MP; i++) begin
                n_chk++;
                if ({cap_vld[i], cap_data[i], cap_x[i], cap_win[i], cap_ovf[i]} !==
                    {1'b1, exp_data[i], exp_x[i], exp_win[i], exp_ovf[i]}) begin
                    n_fail++;
                    $display("FAIL prime line%0d px%0d got vld=%b data=%h x=%0d win=%b ovf=%b want data=%h x=%0d win=%b ovf=%b",
                             ln, i, cap_vld[i], cap_data[i], cap_x[i], cap_win[i], cap_ovf[i],
                             exp_data[i], exp_x[i], exp_win[i], exp_ovf[i]);
                end
            end
        end
        end_frame();
    endtask

    // 3 lines x 4 pixels with pixel = 16*line + col.
    task automatic test_frame_basic(input string tag);
        logic [DW*NL-1:0] want;
        for (int ln = 0; ln < 3; ln++) begin
            for (int i = 0; i < 4; i++) pix_in[i] = DW'(16 * ln + i);
            send_line(4, 1'b0);
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if ({cap_vld[i], cap_data[i], cap_x[i], cap_win[i], cap_ovf[i]} !==
                    {1'b1, exp_data[i], exp_x[i], exp_win[i], exp_ovf[i]}) begin
                    n_fail++;
                    $display("FAIL %s line%0d px%0d got vld=%b data=%h x=%0d win=%b ovf=%b want data=%h x=%0d win=%b ovf=%b",
                             tag, ln, i, cap_vld[i], cap_data[i], cap_x[i], cap_win[i], cap_ovf[i],
                             exp_data[i], exp_x[i], exp_win[i], exp_ovf[i]);
                end
            end
            n_chk++;
            if (gap_vld !== 1'b0 || gap_data !== '0) begin
                n_fail++;
                $display("FAIL %s_gap line%0d got vld=%b data=%h want vld=0 data=0", tag, ln, gap_vld, gap_data);
            end
            if (ln == 0) begin
                n_chk++;
                if (cap_data[2][DW*NL-1:DW] !== '0 || cap_win[2] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_line0_hist got lanes=%h win=%b want 0 0", tag, cap_data[2][DW*NL-1:DW], cap_win[2]);
                end
            end
            if (ln == 1) begin
                want = {10'd0, 10'd2, 10'd18};
                n_chk++;
                if (cap_data[2] !== want) begin
                    n_fail++;
                    $display("FAIL %s_line1_col2 got=%h want=%h", tag, cap_data[2], want);
                end
            end
            if (ln == 2) begin
                want = {10'd1, 10'd17, 10'd33};
                n_chk++;
                if (cap_data[1] !== want || cap_win[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_line2_col1 got data=%h win=%b want data=%h win=1", tag, cap_data[1], cap_win[1], want);
                end
            end
        end
        end_frame();
    endtask

    // Over-long line: pixels past the RAM end lose history and latch oOVF.
    task automatic test_overflow();
        int lens [3] = '{4, 10, 4};
        for (int ln = 0; ln < 3; ln++) begin
            for (int i = 0; i < lens[ln]; i++) pix_in[i] = DW'($urandom);
            send_line(lens[ln], 1'b0);
            for (int i = 0; i < lens[ln]; i++) begin
                n_chk++;
                if ({cap_vld[i], cap_data[i], cap_x[i], cap_win[i], cap_ovf[i]} !==
                    {1'b1, exp_data[i], exp_x[i], exp_win[i], exp_ovf[i]}) begin
                    n_fail++;
                    $display("FAIL ovf line%0d px%0d got vld=%b data=%h x=%0d win=%b ovf=%b want data=%h x=%0d win=%b ovf=%b",
                             ln, i, cap_vld[i], cap_data[i], cap_x[i], cap_win[i], cap_ovf[i],
                             exp_data[i], exp_x[i], exp_win[i], exp_ovf[i]);
                end
            end
            if (ln == 1) begin
                n_chk++;
                if (cap_data[8][DW*NL-1:DW] !== '0 || cap_data[9][DW*NL-1:DW] !== '0 || cap_ovf[8] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_tail got lanes8=%h lanes9=%h ovf=%b want 0 0 1",
                             cap_data[8][DW*NL-1:DW], cap_data[9][DW*NL-1:DW], cap_ovf[8]);
                end
            end
            if (ln == 2) begin
                n_chk++;
                if (cap_x[0] !== '0 || cap_ovf[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_next_line got x=%0d ovf=%b want x=0 ovf=1", cap_x[0], cap_ovf[0]);
                end
            end
        end
        end_frame();
        n_chk++;
        if (bus.oOVF !== 1'b1) begin n_fail++; $display("FAIL ovf_hold_fval_low got=%b want=1", bus.oOVF); end
        for (int i = 0; i < 3; i++) pix_in[i] = DW'($urandom);
        send_line(3, 1'b0);
        n_chk++;
        if (cap_ovf[0] !== 1'b0 || cap_ovf[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear_new_frame got=%b%b want=00", cap_ovf[0], cap_ovf[2]);
        end
        end_frame();
    endtask

    // Five lines: bank rotation 0,1,2,0,1 and full window on later lines.
    task automatic test_wr_sequence();
        for (int ln = 0; ln < 5; ln++) begin
            for (int i = 0; i < 6; i++) pix_in[i] = DW'($urandom);
            send_line(6, 1'b0);
            n_chk++;
            if (line_wr !== WW'(ln % 3)) begin
                n_fail++;
                $display("FAIL wr_seq line%0d got=%0d want=%0d", ln, line_wr, ln % 3);
            end
            for (int i = 0; i < 6; i++) begin
                n_chk++;
                if ({cap_vld[i], cap_data[i], cap_x[i], cap_win[i]} !==
                    {1'b1, exp_data[i], exp_x[i], exp_win[i]}) begin
                    n_fail++;
                    $display("FAIL wr_data line%0d px%0d got vld=%b data=%h x=%0d win=%b want data=%h x=%0d win=%b",
                             ln, i, cap_vld[i], cap_data[i], cap_x[i], cap_win[i], exp_data[i], exp_x[i], exp_win[i]);
                end
            end
        end
        end_frame();
    endtask

    // FVAL and LVAL fall together: state returns to line 0 of a new frame.
    task automatic test_fval_drop();
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 4; i++) pix_in[i] = DW'($urandom);
            send_line(4, ln == 1);
        end
        n_chk++;
        if (bus.WR !== '0) begin n_fail++; $display("FAIL fdrop_wr got=%0d want=0", bus.WR); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) pix_in[i] = DW'($urandom);
        send_line(4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (cap_data[i] !== {20'd0, pix_in[i]} || cap_win[i] !== 1'b0 || cap_vld[i] !== 1'b1) begin
                n_fail++;
                $display("FAIL fdrop_line0 px%0d got vld=%b data=%h win=%b want data=%h win=0",
                         i, cap_vld[i], cap_data[i], cap_win[i], {20'd0, pix_in[i]});
            end
        end
        end_frame();
    endtask

    // Random frames with random line lengths, including short lines over stale RAM.
    task automatic test_random();
        int nlines, len;
        for (int f = 0; f < 4; f++) begin
            nlines = $urandom_range(6, 2);
            for (int ln = 0; ln < nlines; ln++) begin
                len = $urandom_range(10, 1);
                for (int i = 0; i < len; i++) pix_in[i] = DW'($urandom);
                send_line(len, 1'b0);
                for (int i = 0; i < len; i++) begin
                    n_chk++;
                    if ({cap_vld[i], cap_data[i], cap_x[i], cap_win[i], cap_ovf[i]} !==
                        {1'b1, exp_data[i], exp_x[i], exp_win[i], exp_ovf[i]}) begin
                        n_fail++;
                        $display("FAIL rand f%0d line%0d px%0d got vld=%b data=%h x=%0d win=%b ovf=%b want data=%h x=%0d win=%b ovf=%b",
                                 f, ln, i, cap_vld[i], cap_data[i], cap_x[i], cap_win[i], cap_ovf[i],
                                 exp_data[i], exp_x[i], exp_win[i], exp_ovf[i]);
                    end
                end
            end
            end_frame();
        end
    endtask

    // Reset asserted between clock edges mid-line clears outputs immediately.
    task automatic test_reset_midline();
        for (int i = 0; i < 10; i++) pix_in[i] = DW'($urandom);
        send_line(10, 1'b0);
        send_line(3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            pix_in[i] = DW'($urandom);
            m_mem[m_line % NL][i] = pix_in[i];
            bus.mCCD_LVAL = 1'b1;
            bus.mCCD_DATA = pix_in[i];
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (bus.oVALID !== 1'b0)     begin n_fail++; $display("FAIL arst_oVALID got=%b want=0", bus.oVALID); end
        n_chk++; if (bus.oDATA !== '0)        begin n_fail++; $display("FAIL arst_oDATA got=%h want=0", bus.oDATA); end
        n_chk++; if (bus.oX !== '0)           begin n_fail++; $display("FAIL arst_oX got=%0d want=0", bus.oX); end
        n_chk++; if (bus.oWIN_READY !== 1'b0) begin n_fail++; $display("FAIL arst_oWIN_READY got=%b want=0", bus.oWIN_READY); end
        n_chk++; if (bus.oOVF !== 1'b0)       begin n_fail++; $display("FAIL arst_oOVF got=%b want=0", bus.oOVF); end
        n_chk++; if (bus.WR !== '0)           begin n_fail++; $display("FAIL arst_WR got=%0d want=0", bus.WR); end
        bus.mCCD_FVAL = 1'b0;
        bus.mCCD_LVAL = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_line = 0;
        m_ovf  = 1'b0;
        @(negedge clk);
        test_frame_basic("post_rst");
    endtask

    initial begin
        test_reset();
        test_prime();
        test_frame_basic("basic");
        test_overflow();
        test_wr_sequence();
        test_fval_drop();
        test_random();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
